fwft_fifo_pkt_arbiter: RTL and testbench

- Packet-level round-robin arbiter that shares one output link between N FWFT FIFO read ports, typically the virtual-channel buffers of a NoC router output.
- Grant is locked from the first flit of a packet to its last flit, so packets are never interleaved.
- Drives each FIFO's rd_en directly and forwards the granted FIFO's head flit to a valid/ready output.

---
 rtl/fwft_arb_pkg.sv | 32 +++
 rtl/rr_arbiter_onehot.sv | 32 +++
 rtl/fwft_fifo_pkt_arbiter.sv | 170 +++++++++++++++++
 tb/tb_fwft_fifo_pkt_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fwft_arb_pkg.sv
// Shared types and helpers for the FWFT packet arbiter and its round-robin core.
package fwft_arb_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Index width for an N-way select, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Packet "last" flag lives in the top bit of every flit.
  function automatic int last_bit(input int width);
    return width - 1;
  endfunction

  function automatic logic [3:0] onehot2idx(input logic [15:0] oh);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (oh[i]) begin
        idx = idx | 4'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter_onehot.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter_onehot
  import fwft_arb_pkg::*;
#(
  parameter int N = 4,
  localparam int IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  logic             found;
  logic [IDX_W-1:0] idx;

  // Scan requesters in priority order starting at ptr.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = IDX_W'((int'(ptr) + i) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/fwft_fifo_pkt_arbiter.sv
// Packet-locked round-robin arbiter sharing one valid/ready link between N FWFT FIFOs.
// Optional watchdog that releases a starved lock: define FWFT_ARB_WATCHDOG_EN.
module fwft_fifo_pkt_arbiter
  import fwft_arb_pkg::*;
#(
  parameter int N       = 4,
  parameter int WIDTH   = 34,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] fifo_dout,
  input  logic [N-1:0]       fifo_empty,
  output logic [N-1:0]       fifo_rd_en,
  output logic [WIDTH-1:0]   out_flit,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N-1:0]       grant,
  output logic               locked,
  output logic               err_timeout
);

  localparam int IDX_W = idx_w(N);
  localparam int LAST  = last_bit(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_t           state_r, state_nx;
  logic [N-1:0]     grant_r, grant_nx;
  logic             locked_r, locked_nx;
  logic [IDX_W-1:0] rr_ptr_r, rr_ptr_nx;
  logic [IDX_W-1:0] gidx_r, gidx_nx;
  logic [IDX_W-1:0] next_ptr_s;
  logic [N-1:0]     req_s, arb_gnt_s;
  logic [WIDTH-1:0] head_s [N];
  logic             head_empty_s;
  logic             xfer_s;

`ifdef FWFT_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT) + 1;
  logic [WD_W-1:0] wd_cnt_r, wd_cnt_nx;
  logic            err_r, err_nx;
`endif

  for (genvar gi = 0; gi < N; gi++) begin : g_head
    assign head_s[gi] = fifo_dout[gi*WIDTH +: WIDTH];
  end

  assign req_s        = ~fifo_empty;
  assign head_empty_s = fifo_empty[gidx_r];
  assign next_ptr_s   = (gidx_r == LAST_IDX) ? '0 : gidx_r + IDX_W'(1);

  rr_arbiter_onehot #(.N(N)) u_rr (
    .req (req_s),
    .ptr (rr_ptr_r),
    .gnt (arb_gnt_s)
  );

  // Next-state and link outputs; pops are gated by rst so a reset never loses a flit.
  always_comb begin
    state_nx   = state_r;
    grant_nx   = grant_r;
    locked_nx  = locked_r;
    rr_ptr_nx  = rr_ptr_r;
    gidx_nx    = gidx_r;
    out_valid  = 1'b0;
    out_flit   = '0;
    fifo_rd_en = '0;
    xfer_s     = 1'b0;
`ifdef FWFT_ARB_WATCHDOG_EN
    wd_cnt_nx  = wd_cnt_r;
    err_nx     = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        if (|req_s) begin
          state_nx  = LOCKED;
          grant_nx  = arb_gnt_s;
          locked_nx = 1'b1;
          gidx_nx   = IDX_W'(onehot2idx(16'(arb_gnt_s)));
`ifdef FWFT_ARB_WATCHDOG_EN
          wd_cnt_nx = '0;
`endif
        end else begin
          state_nx = IDLE;
        end
      end
      LOCKED: begin
        out_valid = ~head_empty_s;
        if (out_valid) begin
          out_flit = head_s[gidx_r];
        end else begin
          out_flit = '0;
        end
        xfer_s             = out_valid & out_ready & ~rst;
        fifo_rd_en[gidx_r] = xfer_s;
        if (xfer_s && out_flit[LAST]) begin
          state_nx  = IDLE;
          grant_nx  = '0;
          locked_nx = 1'b0;
          rr_ptr_nx = next_ptr_s;
        end
`ifdef FWFT_ARB_WATCHDOG_EN
        else if (xfer_s) begin
          wd_cnt_nx = '0;
        end else if (head_empty_s) begin
          // Only starvation counts; downstream back-pressure never trips the watchdog.
          if (wd_cnt_r == WD_W'(TIMEOUT - 1)) begin
            state_nx  = IDLE;
            grant_nx  = '0;
            locked_nx = 1'b0;
            rr_ptr_nx = next_ptr_s;
            err_nx    = 1'b1;
            wd_cnt_nx = '0;
          end else begin
            wd_cnt_nx = wd_cnt_r + WD_W'(1);
          end
        end else begin
          wd_cnt_nx = wd_cnt_r;
        end
`else
        else begin
          state_nx = LOCKED;
        end
`endif
      end
      default: begin
        state_nx  = IDLE;
        grant_nx  = '0;
        locked_nx = 1'b0;
      end
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      grant_r  <= '0;
      locked_r <= 1'b0;
      rr_ptr_r <= '0;
      gidx_r   <= '0;
    end else begin
      state_r  <= state_nx;
      grant_r  <= grant_nx;
      locked_r <= locked_nx;
      rr_ptr_r <= rr_ptr_nx;
      gidx_r   <= gidx_nx;
    end
  end

`ifdef FWFT_ARB_WATCHDOG_EN
  // Starvation counter and one-cycle error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_r <= '0;
      err_r    <= 1'b0;
    end else begin
      wd_cnt_r <= wd_cnt_nx;
      err_r    <= err_nx;
    end
  end
  assign err_timeout = err_r;
`else
  assign err_timeout = 1'b0;
`endif

  assign grant  = grant_r;
  assign locked = locked_r;

endmodule

// File: tb/tb_fwft_fifo_pkt_arbiter.sv
// Directed bench for fwft_fifo_pkt_arbiter: table-driven cycles plus hand-written corner sequences.
module tb_fwft_fifo_pkt_arbiter;

  localparam int N  = 4;
  localparam int W  = 34;
  localparam int TO = 8;
`ifdef FWFT_ARB_WATCHDOG_EN
  localparam int REFILL = 5;
`else
  localparam int REFILL = 10;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] fifo_dout;
  logic [N-1:0]   fifo_empty;
  logic [N-1:0]   fifo_rd_en;
  logic [W-1:0]   out_flit;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   grant;
  logic           locked;
  logic           err_timeout;

  int n_vec = 0;
  int n_bad = 0;

  fwft_fifo_pkt_arbiter #(.N(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .fifo_dout   (fifo_dout),
    .fifo_empty  (fifo_empty),
    .fifo_rd_en  (fifo_rd_en),
    .out_flit    (out_flit),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .grant       (grant),
    .locked      (locked),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  // FWFT FIFO models: written by the stimulus, popped on rd_en at the clock edge.
  logic [W-1:0] mem [N][64];
  int wp [N] = '{default: 0};
  int rp [N] = '{default: 0};

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (fifo_rd_en[i]) rp[i] <= rp[i] + 1;
    end
  end

  always @* begin
    for (int i = 0; i < N; i++) begin
      fifo_empty[i]       = (rp[i] == wp[i]);
      fifo_dout[i*W +: W] = mem[i][rp[i] % 64];
    end
  end

  typedef struct {
    logic         rdy;
    logic [N-1:0] gnt;
    logic         lck;
    logic         vld;
    logic [W-1:0] flit;
    logic [N-1:0] rd;
    logic         err;
  } vec_t;

  vec_t tab [$];

  function automatic logic [W-1:0] mk(input int f, input int n, input logic last);
    return {last, 25'd0, 4'(f), 4'(n)};
  endfunction

  function automatic vec_t vv(input logic rdy, input logic [N-1:0] g, input logic l,
                              input logic v, input logic [W-1:0] f, input logic [N-1:0] rd,
                              input logic e);
    vec_t t;
    t.rdy = rdy; t.gnt = g; t.lck = l; t.vld = v; t.flit = f; t.rd = rd; t.err = e;
    return t;
  endfunction

  function automatic vec_t idle_v();
    return vv(1'b1, 4'b0000, 1'b0, 1'b0, '0, 4'b0000, 1'b0);
  endfunction

  function automatic vec_t lk(input int g, input logic [W-1:0] f);
    return vv(1'b1, 4'(1 << g), 1'b1, 1'b1, f, 4'(1 << g), 1'b0);
  endfunction

  task automatic push(input int f, input int n, input logic last);
    mem[f][wp[f] % 64] = mk(f, n, last);
    wp[f] = wp[f] + 1;
  endtask

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle's inputs, compare mid-cycle, then advance to just past the next edge.
  task automatic run_vec(input string nm, input vec_t v);
    out_ready = v.rdy;
    #2;
    chk({nm, ".grant"},  W'(grant),       W'(v.gnt));
    chk({nm, ".locked"}, W'(locked),      W'(v.lck));
    chk({nm, ".valid"},  W'(out_valid),   W'(v.vld));
    chk({nm, ".flit"},   out_flit,        v.flit);
    chk({nm, ".rd_en"},  W'(fifo_rd_en),  W'(v.rd));
    chk({nm, ".err"},    W'(err_timeout), W'(v.err));
    @(posedge clk);
    #1;
  endtask

  task automatic run_range(input string nm, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) run_vec($sformatf("%s%0d", nm, i), tab[i]);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // A: 3-flit packet in FIFO2 (0..4); A2: ptr=3 serves FIFO3 before FIFO1 (5..9)
    tab.push_back(idle_v());
    tab.push_back(lk(2, mk(2, 0, 1'b0)));
    tab.push_back(lk(2, mk(2, 1, 1'b0)));
    tab.push_back(lk(2, mk(2, 2, 1'b1)));
    tab.push_back(idle_v());
    tab.push_back(idle_v());
    tab.push_back(lk(3, mk(3, 0, 1'b1)));
    tab.push_back(idle_v());
    tab.push_back(lk(1, mk(1, 0, 1'b1)));
    tab.push_back(idle_v());
    // B: rotation 0..3 (10..18), refill rotation (19..27)
    for (int k = 0; k < N; k++) begin
      tab.push_back(idle_v());
      tab.push_back(lk(k, mk(k, 0, 1'b1)));
    end
    tab.push_back(idle_v());
    for (int k = 0; k < N; k++) begin
      tab.push_back(idle_v());
      tab.push_back(lk(k, mk(k, 1, 1'b1)));
    end
    tab.push_back(idle_v());

    rst = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    run_vec("reset", idle_v());
    rst = 1'b0;

    push(2, 0, 1'b0); push(2, 1, 1'b0); push(2, 2, 1'b1);
    run_range("A", 0, 4);
    push(1, 0, 1'b1); push(3, 0, 1'b1);
    run_range("A2_", 5, 9);

    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < N; k++) push(k, 0, 1'b1);
    run_range("B", 10, 18);
    for (int k = 0; k < N; k++) push(k, 1, 1'b1);
    run_range("B", 19, 27);

    // C: back-pressure mid-packet, FIFO3 waits for the whole FIFO1 packet
    for (int n = 0; n < 4; n++) push(1, n + 1, (n == 3));
    push(3, 1, 1'b0); push(3, 2, 1'b1);
    run_vec("C_idle", idle_v());
    run_vec("C_f0", lk(1, mk(1, 1, 1'b0)));
    run_vec("C_f1", lk(1, mk(1, 2, 1'b0)));
    for (int s = 0; s < 5; s++)
      run_vec($sformatf("C_stall%0d", s), vv(1'b0, 4'b0010, 1'b1, 1'b1, mk(1, 3, 1'b0), 4'b0000, 1'b0));
    run_vec("C_f2", lk(1, mk(1, 3, 1'b0)));
    run_vec("C_f3", lk(1, mk(1, 4, 1'b1)));
    run_vec("C_gap", idle_v());
    run_vec("C_p3a", lk(3, mk(3, 1, 1'b0)));
    run_vec("C_p3b", lk(3, mk(3, 2, 1'b1)));
    run_vec("C_end", idle_v());

    // D: granted FIFO0 runs dry mid-packet, lock holds against FIFO3
    push(0, 2, 1'b0); push(3, 3, 1'b1);
    run_vec("D_idle", idle_v());
    run_vec("D_f0", lk(0, mk(0, 2, 1'b0)));
    for (int s = 0; s < REFILL; s++)
      run_vec($sformatf("D_dry%0d", s), vv(1'b1, 4'b0001, 1'b1, 1'b0, '0, 4'b0000, 1'b0));
    push(0, 3, 1'b0); push(0, 4, 1'b1);
    run_vec("D_f1", lk(0, mk(0, 3, 1'b0)));
    run_vec("D_f2", lk(0, mk(0, 4, 1'b1)));
    run_vec("D_gap", idle_v());
    run_vec("D_p3", lk(3, mk(3, 3, 1'b1)));
    run_vec("D_end", idle_v());

    // E: reset mid-packet leaves the remaining flits in the FIFO
    push(2, 3, 1'b0); push(2, 4, 1'b0); push(2, 5, 1'b1);
    run_vec("E_idle", idle_v());
    run_vec("E_f0", lk(2, mk(2, 3, 1'b0)));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_vec("E_rst", idle_v());
    run_vec("E_f1", lk(2, mk(2, 4, 1'b0)));
    run_vec("E_f2", lk(2, mk(2, 5, 1'b1)));
    run_vec("E_end", idle_v());

    // F: FIFO1 starves after its first flit for TO cycles
    push(1, 5, 1'b0);
    run_vec("F_idle", idle_v());
    run_vec("F_f0", lk(1, mk(1, 5, 1'b0)));
    push(3, 4, 1'b1);
    for (int s = 0; s < TO; s++)
      run_vec($sformatf("F_dry%0d", s), vv(1'b1, 4'b0010, 1'b1, 1'b0, '0, 4'b0000, 1'b0));
`ifdef FWFT_ARB_WATCHDOG_EN
    run_vec("F_err", vv(1'b1, 4'b0000, 1'b0, 1'b0, '0, 4'b0000, 1'b1));
    run_vec("F_p3", lk(3, mk(3, 4, 1'b1)));
    run_vec("F_gap", idle_v());
    push(1, 6, 1'b1);
    run_vec("F_idle2", idle_v());
    run_vec("F_p1", lk(1, mk(1, 6, 1'b1)));
    run_vec("F_end", idle_v());
`else
    for (int s = 0; s < 4; s++)
      run_vec($sformatf("F_hold%0d", s), vv(1'b1, 4'b0010, 1'b1, 1'b0, '0, 4'b0000, 1'b0));
    push(1, 6, 1'b1);
    run_vec("F_f1", lk(1, mk(1, 6, 1'b1)));
    run_vec("F_gap", idle_v());
    run_vec("F_p3", lk(3, mk(3, 4, 1'b1)));
    run_vec("F_end", idle_v());
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
